// File: rtl/arith_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arith_pkg
// Brief    : Shared arithmetic definitions: FSM state encoding and a
//            constant-evaluable ceil(log2) helper.
// Revision : 1.0 - initial release
// ============================================================================
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Smallest r with 2**r >= value; returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage : arith_pkg
`default_nettype wire

// File: rtl/sub_chunk.sv
`default_nettype none
// ============================================================================
// Module   : sub_chunk
// Brief    : Combinational N_BITS-wide ripple-borrow subtractor slice:
//            diff = a - b - bin, bout = borrow out of the top bit.
// Revision : 1.0 - initial release
// ============================================================================
module sub_chunk #(
    parameter int N_BITS = 2
) (
    input  logic [N_BITS-1:0] a,
    input  logic [N_BITS-1:0] b,
    input  logic              bin,
    output logic [N_BITS-1:0] diff,
    output logic              bout
);

    logic [N_BITS:0] w_br;

    assign w_br[0] = bin;

    // Full-subtractor cell per bit; borrow ripples from LSB to MSB.
    generate
        for (genvar i = 0; i < N_BITS; i++) begin : g_bit
            assign diff[i]   = a[i] ^ b[i] ^ w_br[i];
            assign w_br[i+1] = (~a[i] & b[i]) | (~a[i] & w_br[i]) | (b[i] & w_br[i]);
        end
    endgenerate

    assign bout = w_br[N_BITS];

endmodule : sub_chunk
`default_nettype wire

// File: rtl/sub_serial.sv
`default_nettype none
// ============================================================================
// Module   : sub_serial
// Brief    : Multi-cycle unsigned subtractor d = a - b. Consumes CHUNK_BITS
//            per clock LSB first, carrying the borrow in a register. d holds
//            the (N_BITS+1)-bit two's-complement difference.
// Revision : 1.0 - initial release
// ============================================================================
module sub_serial
    import arith_pkg::*;
#(
    parameter int N_BITS     = 8,
    parameter int CHUNK_BITS = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_BITS-1:0] a,
    input  logic [N_BITS-1:0] b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N_BITS:0]   d
);

    localparam int c_N_CHUNKS = N_BITS / CHUNK_BITS;
    localparam int c_CNT_W    = (clog2(c_N_CHUNKS) < 1) ? 1 : clog2(c_N_CHUNKS);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(c_N_CHUNKS - 1);

    state_t              r_state;
    state_t              w_state_next;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_borrow;
    logic [N_BITS-1:0]   r_a;
    logic [N_BITS-1:0]   r_b;
    logic [N_BITS-1:0]   r_res;
    logic [N_BITS:0]     r_d;

    logic [CHUNK_BITS-1:0] w_diff;
    logic                  w_bout;
    logic [N_BITS-1:0]     w_res_next;
    logic                  w_accept;
    logic                  w_last;

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign d         = r_d;

    assign w_accept = in_valid & in_ready;
    assign w_last   = (r_state == BUSY) && (r_cnt == c_LAST);

    sub_chunk #(
        .N_BITS (CHUNK_BITS)
    ) u_sub_chunk (
        .a    (r_a[CHUNK_BITS-1:0]),
        .b    (r_b[CHUNK_BITS-1:0]),
        .bin  (r_borrow),
        .diff (w_diff),
        .bout (w_bout)
    );

    // New chunk enters at the top so after N_CHUNKS shifts the LSB chunk
    // lands at bit 0; a single-chunk configuration has nothing to shift.
    generate
        if (CHUNK_BITS == N_BITS) begin : g_res_full
            assign w_res_next = w_diff;
        end else begin : g_res_shift
            assign w_res_next = {w_diff, r_res[N_BITS-1:CHUNK_BITS]};
        end
    endgenerate

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: accept -> one BUSY cycle per chunk -> hold until consumed.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_state_next = BUSY;
            BUSY:    if (w_last)    w_state_next = DONE;
            DONE:    if (out_ready) w_state_next = IDLE;
            default:                w_state_next = IDLE;
        endcase
    end

    // Datapath: operand capture, chunk shifting, borrow chaining and result latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_borrow <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_d      <= '0;
        end else if (w_accept) begin
            r_a      <= a;
            r_b      <= b;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
        end else if (r_state == BUSY) begin
            r_a      <= r_a >> CHUNK_BITS;
            r_b      <= r_b >> CHUNK_BITS;
            r_res    <= w_res_next;
            r_borrow <= w_bout;
            r_cnt    <= r_cnt + c_CNT_W'(1);
            if (w_last) begin
                r_d <= {w_bout, w_res_next};
            end
        end
    end

endmodule : sub_serial
`default_nettype wire

// File: tb/tb_sub_serial.sv
`default_nettype none
// ============================================================================
// Module   : tb_sub_serial
// Brief    : Directed self-checking bench for sub_serial (N_BITS=8,
//            CHUNK_BITS=2) plus a sampled operand sweep over CHUNK_BITS
//            1/2/4/8 against an arithmetic reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sub_serial;

    logic       clk;
    logic       rst_n;

    // Main directed instance
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [8:0] d;

    // Sweep instances share inputs
    logic       s_in_valid;
    logic [7:0] s_a;
    logic [7:0] s_b;
    logic       s_out_ready;
    logic       s_in_ready  [4];
    logic       s_out_valid [4];
    logic [8:0] s_d         [4];

    int n_checks;
    int n_errors;

    sub_serial #(
        .N_BITS     (8),
        .CHUNK_BITS (2)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d)
    );

    generate
        for (genvar g = 0; g < 4; g++) begin : g_sweep
            sub_serial #(
                .N_BITS     (8),
                .CHUNK_BITS (1 << g)
            ) u_sw (
                .clk       (clk),
                .rst_n     (rst_n),
                .in_valid  (s_in_valid),
                .in_ready  (s_in_ready[g]),
                .a         (s_a),
                .b         (s_b),
                .out_valid (s_out_valid[g]),
                .out_ready (s_out_ready),
                .d         (s_d[g])
            );
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full operation on the main instance with out_ready held high.
    task automatic do_op(input logic [7:0] ta, input logic [7:0] tb, input logic [8:0] exp, input string tag);
        int lat;
        lat = 0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a = ta;
        b = tb;
        check_val({tag, "_rdy_pre"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        while (!out_valid && lat < 10) begin
            tick();
            lat++;
        end
        check_val({tag, "_lat"}, 32'(lat), 32'd4);
        check_val({tag, "_d"}, 32'(d), 32'(exp));
        tick();
        check_val({tag, "_rdy_post"}, 32'(in_ready), 32'd1);
        check_val({tag, "_ov_post"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [7:0] va;
        logic [7:0] vb;
        logic [8:0] exp;
        logic       seen [4];

        n_checks    = 0;
        n_errors    = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        a           = '0;
        b           = '0;
        out_ready   = 1'b0;
        s_in_valid  = 1'b0;
        s_a         = '0;
        s_b         = '0;
        s_out_ready = 1'b1;

        // Reset state
        #1;
        check_val("rst_in_ready", 32'(in_ready), 32'd1);
        check_val("rst_out_valid", 32'(out_valid), 32'd0);
        check_val("rst_d", 32'(d), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Basic subtraction cases, including borrow-out and extremes
        do_op(8'd200, 8'd55,  9'h091, "t200_55");
        do_op(8'd55,  8'd200, 9'h16F, "t55_200");
        do_op(8'd0,   8'd1,   9'h1FF, "t0_1");
        do_op(8'd255, 8'd255, 9'h000, "t255_255");

        // Backpressure: result held while consumer stalls, extra requests ignored
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a = 8'd10;
        b = 8'd3;
        tick();
        in_valid = 1'b0;
        for (int n = 1; n <= 3; n++) begin
            tick();
            check_val("bp_busy_ov", 32'(out_valid), 32'd0);
        end
        tick();
        check_val("bp_ov", 32'(out_valid), 32'd1);
        check_val("bp_d", 32'(d), 32'h007);
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            a = 8'($urandom);
            b = 8'($urandom);
            tick();
            check_val("bp_hold_ov", 32'(out_valid), 32'd1);
            check_val("bp_hold_d", 32'(d), 32'h007);
            check_val("bp_hold_rdy", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check_val("bp_rel_rdy", 32'(in_ready), 32'd1);
        check_val("bp_rel_ov", 32'(out_valid), 32'd0);
        check_val("bp_rel_d", 32'(d), 32'h007);
        tick();
        check_val("bp_idle_ov", 32'(out_valid), 32'd0);

        // Operands change every BUSY cycle; result must follow the captured pair
        in_valid = 1'b1;
        a = 8'd100;
        b = 8'd1;
        tick();
        in_valid = 1'b0;
        for (int n = 1; n <= 4; n++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            tick();
            if (n < 4) check_val("oc_busy_ov", 32'(out_valid), 32'd0);
        end
        check_val("oc_ov", 32'(out_valid), 32'd1);
        check_val("oc_d", 32'(d), 32'h063);
        tick();
        check_val("oc_rdy", 32'(in_ready), 32'd1);

        // Asynchronous reset in the middle of BUSY
        in_valid = 1'b1;
        a = 8'd50;
        b = 8'd20;
        tick();
        in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        check_val("arst_ov", 32'(out_valid), 32'd0);
        check_val("arst_d", 32'(d), 32'd0);
        check_val("arst_rdy", 32'(in_ready), 32'd1);
        tick();
        tick();
        rst_n = 1'b1;
        for (int n = 0; n < 6; n++) begin
            tick();
            check_val("arst_no_out", 32'(out_valid), 32'd0);
        end
        do_op(8'd7, 8'd9, 9'h1FE, "t7_9");

        // Sampled sweep over all chunk widths against arithmetic reference
        for (int ia = 0; ia < 32; ia++) begin
            for (int ib = 0; ib < 32; ib++) begin
                va  = 8'(ia * 8 + (ia & 7));
                vb  = 8'(255 - (ib * 8 + ((ib * 3) & 7)));
                exp = {1'b0, va} - {1'b0, vb};
                s_a = va;
                s_b = vb;
                s_in_valid = 1'b1;
                for (int j = 0; j < 4; j++) seen[j] = 1'b0;
                tick();
                s_in_valid = 1'b0;
                for (int n = 1; n <= 9; n++) begin
                    tick();
                    for (int j = 0; j < 4; j++) begin
                        if (s_out_valid[j] && !seen[j]) begin
                            seen[j] = 1'b1;
                            check_val($sformatf("sw_lat_c%0d", 1 << j), 32'(n), 32'(8 >> j));
                            check_val($sformatf("sw_d_c%0d_%0d_%0d", 1 << j, va, vb), 32'(s_d[j]), 32'(exp));
                        end
                    end
                end
                for (int j = 0; j < 4; j++) begin
                    check_val($sformatf("sw_done_c%0d", 1 << j), 32'(seen[j]), 32'd1);
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_sub_serial
`default_nettype wire
